hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that generates the stall (enable) and flush (clear) controls consumed by the PC register, the IF/ID register and the ID/EX register. It detects load-use hazards between the instruction in ID and a load in EX, flushes the two younger stages on a taken branch resolved in EX, and freezes the pipeline on a halt until a resume pulse arrives. It also keeps 32-bit cycle, stall and flush statistics counters for the display panel.

## Interface
- STALL_CYCLES, default 1: bubbles inserted per load-use hazard, legal range 1..15.
- in_CLK  input  1  system clock; all state updates on the rising edge.
- in_CLR  input  1  asynchronous, active-high reset.
- in_id_rs  input  5  rs field of the instruction in ID.
- in_id_rt  input  5  rt field of the instruction in ID.
- in_id_uses_rs  input  1  the ID instruction reads rs.
- in_id_uses_rt  input  1  the ID instruction reads rt.
- in_ex_memread  input  1  the EX instruction is a load.
- in_ex_rd  input  5  destination register of the EX instruction.
- in_ex_branch_taken  input  1  the EX instruction is a taken branch or jump.
- in_halt  input  1  the EX instruction is a halt.
- in_go  input  1  resume request, sampled only in HALT.
- out_pc_en  output  1  PC write enable.
- out_ifid_en  output  1  IF/ID enable.
- out_ifid_clr  output  1  IF/ID clear.
- out_idex_en  output  1  ID/EX enable.
- out_idex_clr  output  1  ID/EX clear (bubble insert).
- out_halted  output  1  high in HALT.
- out_cycles  output  32  count of non-halted cycles.
- out_stalls  output  32  count of stall cycles.
- out_flushes  output  32  count of branch flush events.

## Operation
- States: RUN, STALL, HALT. A 4-bit bubble counter `cnt` is used in STALL.
- Hazard term: hz = in_ex_memread & (in_ex_rd != 0) & ((in_id_uses_rs & in_id_rs == in_ex_rd) | (in_id_uses_rt & in_id_rt == in_ex_rd)).
- RUN decisions, highest priority first:
  - **in_halt:** all enables 0, clears 0. Next state HALT.
  - **in_ex_branch_taken:** pc_en=1, ifid_en=1, ifid_clr=1, idex_en=1, idex_clr=1. out_flushes increments. Stay in RUN.
  - **hz:** pc_en=0, ifid_en=0, idex_en=1, idex_clr=1, ifid_clr=0. out_stalls increments.
    - If STALL_CYCLES=1, stay in RUN.
    - Otherwise go to STALL with cnt=STALL_CYCLES-1.
  - **otherwise:** all enables 1, all clears 0.
- STALL:
  - Outputs are the same as for the hz case: PC and IF/ID held, bubble into ID/EX. out_stalls increments every cycle.
  - in_halt and in_ex_branch_taken are ignored, because EX holds a bubble.
  - cnt decrements. When cnt==1, the next state is RUN.
- HALT:
  - All enables 0, all clears 0, out_halted=1.
  - in_go=1 moves to RUN on the next edge. in_go is ignored in other states.
- out_cycles increments in every RUN or STALL cycle and holds in HALT.
- All counters wrap modulo 2^32.
- Control outputs are combinational from the state and the inputs. Counters and state are registered.

## Timing
- While in_CLR=1, outputs are forced asynchronously:
  - pc_en=0, ifid_en=0, idex_en=0.
  - ifid_clr=1, idex_clr=1.
  - out_halted=0.
- On reset, state=RUN, cnt=0 and all counters are 0.
- After in_CLR falls, RUN behaviour starts immediately (combinationally). The first edge counts as cycle 1.
- Load-use hazard latency:
  - The hazard is visible in the same cycle as hz.
  - The dependent instruction leaves ID STALL_CYCLES edges later.
  - Total stall cycles per hazard equal STALL_CYCLES.
- Branch flush takes exactly 1 cycle. The branch target is fetched on the same edge that flushes.
- Halt takes effect in the same cycle as in_halt. out_halted rises after the next edge.
- Resume: with in_go=1 in HALT, the following cycle is RUN. In that cycle in_halt is still evaluated, so a halt still sitting in EX re-halts. The EX stage is expected to clear in_halt after a resume.
- Simultaneous events in RUN resolve by priority: halt, then branch, then hz. A branch with a simultaneous hz flushes only and does not count a stall.
- Reset asserted in the middle of STALL or HALT returns to RUN with cnt=0 and counters cleared.

## Test plan
- **Reset:** assert in_CLR mid-cycle.
  - Expect out_ifid_clr=out_idex_clr=1 and all enables 0 immediately.
  - After release with no inputs active, all enables are 1 and counters are 0.
- **Load-use, STALL_CYCLES=1:** ex_memread=1, ex_rd=5, id_rs=5, uses_rs=1 for one cycle.
  - Expect pc_en=0, ifid_en=0, idex_clr=1 for 1 cycle.
  - out_stalls=1.
  - With ex_rd=0 instead, no stall occurs.
- **Load-use, STALL_CYCLES=3:** apply the same hazard for one cycle.
  - Expect 3 consecutive stall cycles, then RUN. out_stalls=3.
  - A branch_taken pulse during the 2nd stall cycle is ignored and out_flushes stays 0.
- **Branch and hazard together:** branch_taken=1 together with hz.
  - Expect ifid_clr=idex_clr=1 and pc_en=1.
  - out_flushes=1, out_stalls=0.
- **Halt and resume:** pulse in_halt.
  - Expect all enables 0 at once and out_halted=1 after the edge.
  - out_cycles holds for 10 cycles.
  - After in_go, the state returns to RUN and out_cycles resumes counting.
- **Wrap-around:** force out_cycles to 0xFFFFFFFF through a backdoor, run 1 cycle, expect 0x00000000.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and halt/resume for PC, IF/ID and ID/EX.
// Control outputs are combinational from state and inputs; state and statistics counters are registered.
module hazard_ctrl #(
   parameter int unsigned STALL_CYCLES = 1
) (
   input  logic        in_CLK,
   input  logic        in_CLR,
   input  logic [4:0]  in_id_rs,
   input  logic [4:0]  in_id_rt,
   input  logic        in_id_uses_rs,
   input  logic        in_id_uses_rt,
   input  logic        in_ex_memread,
   input  logic [4:0]  in_ex_rd,
   input  logic        in_ex_branch_taken,
   input  logic        in_halt,
   input  logic        in_go,
   output logic        out_pc_en,
   output logic        out_ifid_en,
   output logic        out_ifid_clr,
   output logic        out_idex_en,
   output logic        out_idex_clr,
   output logic        out_halted,
   output logic [31:0] out_cycles,
   output logic [31:0] out_stalls,
   output logic [31:0] out_flushes
);

   typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(STALL_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] cycles_q, cycles_d;
   logic [31:0] stalls_q, stalls_d;
   logic [31:0] flushes_q, flushes_d;
   logic        hz;
   logic        stall_inc;
   logic        flush_inc;

   always_comb begin
      hz = in_ex_memread && (in_ex_rd != 5'd0) &&
           ((in_id_uses_rs && (in_id_rs == in_ex_rd)) ||
            (in_id_uses_rt && (in_id_rt == in_ex_rd)));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      out_pc_en    = 1'b1;
      out_ifid_en  = 1'b1;
      out_ifid_clr = 1'b0;
      out_idex_en  = 1'b1;
      out_idex_clr = 1'b0;
      out_halted   = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      case (state_q)
         RUN: begin
            if (in_halt) begin
               out_pc_en   = 1'b0;
               out_ifid_en = 1'b0;
               out_idex_en = 1'b0;
               state_d     = HALT;
            end else if (in_ex_branch_taken) begin
               out_ifid_clr = 1'b1;
               out_idex_clr = 1'b1;
               flush_inc    = 1'b1;
            end else if (hz) begin
               out_pc_en    = 1'b0;
               out_ifid_en  = 1'b0;
               out_idex_clr = 1'b1;
               stall_inc    = 1'b1;
               if (STALL_CYCLES > 1) begin
                  state_d = STALL;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         STALL: begin
            // EX holds a bubble here, so halt and branch requests cannot be real.
            out_pc_en    = 1'b0;
            out_ifid_en  = 1'b0;
            out_idex_clr = 1'b1;
            stall_inc    = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end
         end
         HALT: begin
            out_pc_en   = 1'b0;
            out_ifid_en = 1'b0;
            out_idex_en = 1'b0;
            out_halted  = 1'b1;
            if (in_go) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase
      if (in_CLR) begin
         out_pc_en    = 1'b0;
         out_ifid_en  = 1'b0;
         out_idex_en  = 1'b0;
         out_ifid_clr = 1'b1;
         out_idex_clr = 1'b1;
         out_halted   = 1'b0;
      end
   end

   always_comb begin
      cycles_d  = (state_q != HALT) ? cycles_q + 32'd1 : cycles_q;
      stalls_d  = stall_inc ? stalls_q + 32'd1 : stalls_q;
      flushes_d = flush_inc ? flushes_q + 32'd1 : flushes_q;
   end

   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR) begin
         state_q   <= RUN;
         cnt_q     <= 4'd0;
         cycles_q  <= 32'd0;
         stalls_q  <= 32'd0;
         flushes_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cycles_q  <= cycles_d;
         stalls_q  <= stalls_d;
         flushes_q <= flushes_d;
      end
   end

   assign out_cycles  = cycles_q;
   assign out_stalls  = stalls_q;
   assign out_flushes = flushes_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with one instance per stall depth (1 and 3) sharing the same stimulus.
module tb_hazard_ctrl;

   logic        clk;
   logic        clr;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        uses_rs, uses_rt, memread, br, halt, go;

   logic        a_pc_en, a_ifid_en, a_ifid_clr, a_idex_en, a_idex_clr, a_halted;
   logic [31:0] a_cycles, a_stalls, a_flushes;
   logic        b_pc_en, b_ifid_en, b_ifid_clr, b_idex_en, b_idex_clr, b_halted;
   logic [31:0] b_cycles, b_stalls, b_flushes;

   int tests = 0;
   int fails = 0;

   hazard_ctrl #(.STALL_CYCLES(1)) u1 (
      .in_CLK(clk), .in_CLR(clr), .in_id_rs(id_rs), .in_id_rt(id_rt),
      .in_id_uses_rs(uses_rs), .in_id_uses_rt(uses_rt), .in_ex_memread(memread),
      .in_ex_rd(ex_rd), .in_ex_branch_taken(br), .in_halt(halt), .in_go(go),
      .out_pc_en(a_pc_en), .out_ifid_en(a_ifid_en), .out_ifid_clr(a_ifid_clr),
      .out_idex_en(a_idex_en), .out_idex_clr(a_idex_clr), .out_halted(a_halted),
      .out_cycles(a_cycles), .out_stalls(a_stalls), .out_flushes(a_flushes)
   );

   hazard_ctrl #(.STALL_CYCLES(3)) u3 (
      .in_CLK(clk), .in_CLR(clr), .in_id_rs(id_rs), .in_id_rt(id_rt),
      .in_id_uses_rs(uses_rs), .in_id_uses_rt(uses_rt), .in_ex_memread(memread),
      .in_ex_rd(ex_rd), .in_ex_branch_taken(br), .in_halt(halt), .in_go(go),
      .out_pc_en(b_pc_en), .out_ifid_en(b_ifid_en), .out_ifid_clr(b_ifid_clr),
      .out_idex_en(b_idex_en), .out_idex_clr(b_idex_clr), .out_halted(b_halted),
      .out_cycles(b_cycles), .out_stalls(b_stalls), .out_flushes(b_flushes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      uses_rs = 1'b0; uses_rt = 1'b0; memread = 1'b0;
      br = 1'b0; halt = 1'b0; go = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      tick();
      #2;
      clr = 1'b1;
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted} !== 6'b000110) begin
         fails++;
         $display("FAIL reset_forced_u1: got %b want 000110",
                  {a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted});
      end
      tests++;
      if ({b_pc_en, b_ifid_en, b_idex_en, b_ifid_clr, b_idex_clr, b_halted} !== 6'b000110) begin
         fails++;
         $display("FAIL reset_forced_u3: got %b want 000110",
                  {b_pc_en, b_ifid_en, b_idex_en, b_ifid_clr, b_idex_clr, b_halted});
      end
      tick();
      clr = 1'b0;
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted} !== 6'b111000) begin
         fails++;
         $display("FAIL reset_release_ctrl: got %b want 111000",
                  {a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted});
      end
      tests++;
      if ({a_cycles, a_stalls, a_flushes} !== 96'd0) begin
         fails++;
         $display("FAIL reset_counters: got %h %h %h want 0 0 0", a_cycles, a_stalls, a_flushes);
      end
      tick();
      tests++;
      if (a_cycles !== 32'd1) begin
         fails++;
         $display("FAIL reset_first_cycle: got %0d want 1", a_cycles);
      end
   endtask

   task automatic test_loaduse_1();
      do_reset();
      memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; uses_rs = 1'b1;
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr} !== 5'b00101) begin
         fails++;
         $display("FAIL lu1_stall: got %b want 00101",
                  {a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr});
      end
      tick();
      idle();
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_idex_clr, a_stalls} !== {3'b110, 32'd1}) begin
         fails++;
         $display("FAIL lu1_after: got pc=%b ifid=%b idclr=%b stalls=%0d want 1 1 0 1",
                  a_pc_en, a_ifid_en, a_idex_clr, a_stalls);
      end
      memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; uses_rs = 1'b1;
      #1;
      tests++;
      if (a_pc_en !== 1'b1) begin
         fails++;
         $display("FAIL lu1_rd0: got pc_en=%b want 1", a_pc_en);
      end
      ex_rd = 5'd7; id_rs = 5'd7; uses_rs = 1'b0; id_rt = 5'd3; uses_rt = 1'b1;
      #1;
      tests++;
      if (a_pc_en !== 1'b1) begin
         fails++;
         $display("FAIL lu1_unused_rs: got pc_en=%b want 1", a_pc_en);
      end
      id_rt = 5'd7;
      #1;
      tests++;
      if ({a_pc_en, a_idex_clr} !== 2'b01) begin
         fails++;
         $display("FAIL lu1_rt_match: got %b want 01", {a_pc_en, a_idex_clr});
      end
      tick();
      idle();
      #1;
      tests++;
      if (a_stalls !== 32'd2) begin
         fails++;
         $display("FAIL lu1_stall_count: got %0d want 2", a_stalls);
      end
   endtask

   task automatic test_loaduse_3();
      do_reset();
      memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; uses_rs = 1'b1;
      #1;
      tests++;
      if ({b_pc_en, b_ifid_en, b_idex_clr} !== 3'b001) begin
         fails++;
         $display("FAIL lu3_stall1: got %b want 001", {b_pc_en, b_ifid_en, b_idex_clr});
      end
      tick();
      idle();
      br = 1'b1;
      #1;
      tests++;
      if ({b_pc_en, b_ifid_en, b_ifid_clr, b_idex_clr} !== 4'b0001) begin
         fails++;
         $display("FAIL lu3_stall2_branch: got %b want 0001",
                  {b_pc_en, b_ifid_en, b_ifid_clr, b_idex_clr});
      end
      tick();
      br = 1'b0;
      #1;
      tests++;
      if ({b_pc_en, b_idex_clr} !== 2'b01) begin
         fails++;
         $display("FAIL lu3_stall3: got %b want 01", {b_pc_en, b_idex_clr});
      end
      tick();
      tests++;
      if ({b_pc_en, b_ifid_en, b_idex_clr} !== 3'b110) begin
         fails++;
         $display("FAIL lu3_back_to_run: got %b want 110", {b_pc_en, b_ifid_en, b_idex_clr});
      end
      tests++;
      if ({b_stalls, b_flushes, b_cycles} !== {32'd3, 32'd0, 32'd3}) begin
         fails++;
         $display("FAIL lu3_counters: got stalls=%0d flushes=%0d cycles=%0d want 3 0 3",
                  b_stalls, b_flushes, b_cycles);
      end
   endtask

   task automatic test_branch_hz();
      do_reset();
      br = 1'b1; memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; uses_rt = 1'b1;
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_ifid_clr, a_idex_en, a_idex_clr} !== 5'b11111) begin
         fails++;
         $display("FAIL br_hz_ctrl: got %b want 11111",
                  {a_pc_en, a_ifid_en, a_ifid_clr, a_idex_en, a_idex_clr});
      end
      tick();
      idle();
      #1;
      tests++;
      if ({a_flushes, a_stalls, b_flushes, b_stalls} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
         fails++;
         $display("FAIL br_hz_counts: got u1 %0d/%0d u3 %0d/%0d want 1/0 1/0",
                  a_flushes, a_stalls, b_flushes, b_stalls);
      end
      tests++;
      if (b_pc_en !== 1'b1) begin
         fails++;
         $display("FAIL br_hz_no_stall_state: got pc_en=%b want 1", b_pc_en);
      end
   endtask

   task automatic test_halt_resume();
      do_reset();
      halt = 1'b1;
      #1;
      tests++;
      if ({a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted} !== 6'b000000) begin
         fails++;
         $display("FAIL halt_immediate: got %b want 000000",
                  {a_pc_en, a_ifid_en, a_idex_en, a_ifid_clr, a_idex_clr, a_halted});
      end
      tick();
      halt = 1'b0;
      #1;
      tests++;
      if ({a_halted, a_cycles} !== {1'b1, 32'd1}) begin
         fails++;
         $display("FAIL halt_entered: got halted=%b cycles=%0d want 1 1", a_halted, a_cycles);
      end
      memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; uses_rs = 1'b1; br = 1'b1;
      repeat (10) tick();
      tests++;
      if ({a_pc_en, a_halted, a_cycles, a_stalls, a_flushes} !== {2'b01, 32'd1, 32'd0, 32'd0}) begin
         fails++;
         $display("FAIL halt_hold: got pc=%b halted=%b cycles=%0d stalls=%0d flushes=%0d want 0 1 1 0 0",
                  a_pc_en, a_halted, a_cycles, a_stalls, a_flushes);
      end
      idle();
      go = 1'b1;
      tick();
      go = 1'b0;
      #1;
      tests++;
      if ({a_halted, a_pc_en, a_ifid_en, a_idex_en, b_halted} !== 5'b01110) begin
         fails++;
         $display("FAIL resume_run: got %b want 01110",
                  {a_halted, a_pc_en, a_ifid_en, a_idex_en, b_halted});
      end
      tick();
      tests++;
      if (a_cycles !== 32'd2) begin
         fails++;
         $display("FAIL resume_count: got %0d want 2", a_cycles);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; uses_rs = 1'b1;
      tick();
      idle();
      #1;
      clr = 1'b1;
      #1;
      clr = 1'b0;
      #1;
      tests++;
      if ({b_pc_en, b_ifid_en, b_idex_clr, b_stalls} !== {3'b110, 32'd0}) begin
         fails++;
         $display("FAIL reset_mid_stall: got pc=%b ifid=%b idclr=%b stalls=%0d want 1 1 0 0",
                  b_pc_en, b_ifid_en, b_idex_clr, b_stalls);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      force u1.cycles_q = 32'hFFFF_FFFF;
      #1;
      release u1.cycles_q;
      #1;
      tests++;
      if (a_cycles !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL wrap_preload: got %h want ffffffff", a_cycles);
      end
      tick();
      tests++;
      if (a_cycles !== 32'h0000_0000) begin
         fails++;
         $display("FAIL wrap_rollover: got %h want 00000000", a_cycles);
      end
   endtask

   initial begin
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      test_reset();
      test_loaduse_1();
      test_loaduse_3();
      test_branch_hz();
      test_halt_resume();
      test_reset_mid_stall();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
